sim_exit_monitor: RTL and testbench

Synthesizable, parametrised simulation-exit monitor for NCH harts, instantiated beside the SoC model in the testbench top. It decodes per-hart tohost writes, counts cycles, enforces a global cycle timeout and a per-hart no-commit stall watchdog, and latches a single terminal verdict. The verdict is pass, tohost fail, timeout or stall. The bench reads the verdict and prints or finishes on it. It also drives the waveform dump window.

---
 rtl/sim_exit_monitor.sv | 195 +++++++++++++++++++
 tb/tb_sim_exit_monitor.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_exit_monitor.sv
// Simulation-exit monitor: per-hart tohost decode, cycle timeout and verdict latch.
// Optional per-channel no-commit watchdog is built when SIM_EXIT_STALL_WATCHDOG_EN is defined.
//
// state | meaning
// RUN   | counting cycles, decoding tohost writes, watching timeout/stall
// PASS  | every channel reported pass (terminal until reset)
// FAIL  | tohost fail, stall or timeout latched (terminal until reset)
module sim_exit_monitor #(
  parameter int NCH         = 1,
  parameter int DATA_W      = 64,
  parameter int CNT_W       = 64,
  parameter int STALL_W     = 17,
  parameter int STALL_LIMIT = 65536,
  localparam int CHAN_W     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [CNT_W-1:0]      cfg_max_cycles,
  input  logic [CNT_W-1:0]      cfg_dump_start,
  input  logic [CNT_W-1:0]      cfg_dump_stop,
  input  logic [NCH-1:0]        ch_valid,
  input  logic [NCH*DATA_W-1:0] ch_data,
  input  logic [NCH-1:0]        commit,
  output logic                  done,
  output logic                  pass,
  output logic                  fail,
  output logic [2:0]            reason,
  output logic [DATA_W-2:0]     fail_code,
  output logic [CHAN_W-1:0]     fail_chan,
  output logic [CNT_W-1:0]      cycle,
  output logic                  dump_en
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2
  } state_e;

  localparam logic [2:0] RSN_NONE    = 3'd0;
  localparam logic [2:0] RSN_PASS    = 3'd1;
  localparam logic [2:0] RSN_TOHOST  = 3'd2;
  localparam logic [2:0] RSN_TIMEOUT = 3'd3;
  localparam logic [2:0] RSN_STALL   = 3'd4;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cycle_q, cycle_d;
  logic [NCH-1:0]      passed_q, passed_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic                fail_q, fail_d;
  logic [2:0]          reason_q, reason_d;
  logic [DATA_W-2:0]   fail_code_q, fail_code_d;
  logic [CHAN_W-1:0]   fail_chan_q, fail_chan_d;

  logic [NCH-1:0]      new_pass;
  logic [NCH-1:0]      tohost_fail;
  logic [NCH-1:0]      stall_hit;
  logic [DATA_W-1:0]   wr_data;
  logic [DATA_W-2:0]   tohost_code;
  logic [CHAN_W-1:0]   tohost_chan;
  logic [CHAN_W-1:0]   stall_chan;
  logic                timeout;

  // Descending scan so the lowest failing channel is the one left in tohost_code/chan.
  always_comb begin : tohost_decode
    new_pass    = '0;
    tohost_fail = '0;
    tohost_code = '0;
    tohost_chan = '0;
    wr_data     = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      wr_data = ch_data[i*DATA_W +: DATA_W];
      if (ch_valid[i] && !passed_q[i] && wr_data[0]) begin
        if (wr_data == DATA_W'(1)) begin
          new_pass[i] = 1'b1;
        end else begin
          tohost_fail[i] = 1'b1;
          tohost_code    = wr_data[DATA_W-1:1];
          tohost_chan    = CHAN_W'(i);
        end
      end
    end
  end

`ifdef SIM_EXIT_STALL_WATCHDOG_EN
  logic [NCH-1:0][STALL_W-1:0] stall_q, stall_d;

  // A hit is flagged on the edge where the counter arrives at the limit.
  always_comb begin : stall_watch
    stall_d    = stall_q;
    stall_hit  = '0;
    stall_chan = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (state_q == ST_RUN && !passed_q[i]) begin
        stall_d[i] = commit[i] ? '0 : stall_q[i] + 1'b1;
        if (stall_d[i] == STALL_W'(STALL_LIMIT)) begin
          stall_hit[i] = 1'b1;
          stall_chan   = CHAN_W'(i);
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) stall_q <= '0;
    else       stall_q <= stall_d;
  end
`else
  logic unused_stall_inputs;
  assign unused_stall_inputs = ^{commit, STALL_W'(STALL_LIMIT)};
  assign stall_hit  = '0;
  assign stall_chan = '0;
`endif

  assign timeout = (cfg_max_cycles != '0) && (cycle_q >= cfg_max_cycles);

  always_comb begin : next_state
    state_d     = state_q;
    cycle_d     = cycle_q;
    passed_d    = passed_q;
    done_d      = done_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    reason_d    = reason_q;
    fail_code_d = fail_code_q;
    fail_chan_d = fail_chan_q;
    if (state_q == ST_RUN) begin
      if (~&cycle_q) cycle_d = cycle_q + 1'b1;
      passed_d = passed_q | new_pass;
      if (|tohost_fail) begin
        state_d     = ST_FAIL;
        reason_d    = RSN_TOHOST;
        fail_code_d = tohost_code;
        fail_chan_d = tohost_chan;
      end else if (|stall_hit) begin
        state_d     = ST_FAIL;
        reason_d    = RSN_STALL;
        fail_code_d = '0;
        fail_chan_d = stall_chan;
      end else if (timeout) begin
        state_d     = ST_FAIL;
        reason_d    = RSN_TIMEOUT;
        fail_code_d = '0;
        fail_chan_d = '0;
      end else if (&passed_d) begin
        state_d  = ST_PASS;
        reason_d = RSN_PASS;
      end
      if (state_d == ST_FAIL) begin
        done_d = 1'b1;
        fail_d = 1'b1;
      end
      if (state_d == ST_PASS) begin
        done_d = 1'b1;
        pass_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RUN;
      cycle_q     <= '0;
      passed_q    <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      reason_q    <= RSN_NONE;
      fail_code_q <= '0;
      fail_chan_q <= '0;
    end else begin
      state_q     <= state_d;
      cycle_q     <= cycle_d;
      passed_q    <= passed_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      reason_q    <= reason_d;
      fail_code_q <= fail_code_d;
      fail_chan_q <= fail_chan_d;
    end
  end

  assign done      = done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign reason    = reason_q;
  assign fail_code = fail_code_q;
  assign fail_chan = fail_chan_q;
  assign cycle     = cycle_q;
  assign dump_en   = (state_q == ST_RUN) && (cycle_q >= cfg_dump_start) &&
                     ((cfg_dump_stop == '0) || (cycle_q < cfg_dump_stop));

endmodule

// File: tb/tb_sim_exit_monitor.sv
// Directed bench for sim_exit_monitor: one NCH=1 instance and one NCH=2 instance
// (STALL_LIMIT=16) sharing clock, reset and configuration.
module tb_sim_exit_monitor;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] cfg_max_cycles = '0;
  logic [63:0] cfg_dump_start = '0;
  logic [63:0] cfg_dump_stop  = '0;

  logic        ch_valid1 = 1'b0;
  logic [63:0] ch_data1  = '0;
  logic        commit1   = 1'b1;
  logic        done1, pass1, fail1, dump_en1;
  logic [2:0]  reason1;
  logic [62:0] fail_code1;
  logic [0:0]  fail_chan1;
  logic [63:0] cycle1;

  logic [1:0]   ch_valid2 = '0;
  logic [127:0] ch_data2  = '0;
  logic [1:0]   commit2   = 2'b11;
  logic         done2, pass2, fail2, dump_en2;
  logic [2:0]   reason2;
  logic [62:0]  fail_code2;
  logic [0:0]   fail_chan2;
  logic [63:0]  cycle2;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  sim_exit_monitor #(.NCH(1)) u_dut1 (
    .clock(clock), .reset(reset),
    .cfg_max_cycles(cfg_max_cycles), .cfg_dump_start(cfg_dump_start), .cfg_dump_stop(cfg_dump_stop),
    .ch_valid(ch_valid1), .ch_data(ch_data1), .commit(commit1),
    .done(done1), .pass(pass1), .fail(fail1), .reason(reason1),
    .fail_code(fail_code1), .fail_chan(fail_chan1), .cycle(cycle1), .dump_en(dump_en1)
  );

  sim_exit_monitor #(.NCH(2), .STALL_LIMIT(16)) u_dut2 (
    .clock(clock), .reset(reset),
    .cfg_max_cycles(cfg_max_cycles), .cfg_dump_start(cfg_dump_start), .cfg_dump_stop(cfg_dump_stop),
    .ch_valid(ch_valid2), .ch_data(ch_data2), .commit(commit2),
    .done(done2), .pass(pass2), .fail(fail2), .reason(reason2),
    .fail_code(fail_code2), .fail_chan(fail_chan2), .cycle(cycle2), .dump_en(dump_en2)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Leaves the bench 1 time unit after an edge with reset low; the next edge is edge 1.
  task automatic do_reset();
    reset     = 1'b1;
    ch_valid1 = 1'b0; ch_data1 = '0; commit1 = 1'b1;
    ch_valid2 = '0;   ch_data2 = '0; commit2 = 2'b11;
    step(2);
    reset = 1'b0;
  endtask

  task automatic wr2(input logic [1:0] v, input logic [63:0] d0, input logic [63:0] d1);
    ch_valid2 = v;
    ch_data2  = {d1, d0};
    step(1);
    ch_valid2 = '0;
    ch_data2  = '0;
  endtask

  task automatic test_reset();
    cfg_max_cycles = '0; cfg_dump_start = '0; cfg_dump_stop = '0;
    reset = 1'b1;
    step(2);
    tests++;
    if ({done2, pass2, fail2, reason2, fail_code2, fail_chan2, cycle2, dump_en2} !==
        {1'b0, 1'b0, 1'b0, 3'd0, 63'd0, 1'b0, 64'd0, 1'b1}) begin
      fails++;
      $display("FAIL reset_dut2 got d=%b p=%b f=%b r=%0d code=%h ch=%0d cyc=%0d dump=%b exp all 0, dump=1",
               done2, pass2, fail2, reason2, fail_code2, fail_chan2, cycle2, dump_en2);
    end
    tests++;
    if ({done1, pass1, fail1, reason1, fail_code1, fail_chan1, cycle1, dump_en1} !==
        {1'b0, 1'b0, 1'b0, 3'd0, 63'd0, 1'b0, 64'd0, 1'b1}) begin
      fails++;
      $display("FAIL reset_dut1 got d=%b p=%b f=%b r=%0d code=%h ch=%0d cyc=%0d dump=%b exp all 0, dump=1",
               done1, pass1, fail1, reason1, fail_code1, fail_chan1, cycle1, dump_en1);
    end
    do_reset();
    step(1);
    tests++;
    if (cycle2 !== 64'd1) begin
      fails++;
      $display("FAIL first_edge_cycle got %0d exp 1", cycle2);
    end
  endtask

  task automatic test_pass_single();
    cfg_max_cycles = '0;
    do_reset();
    step(49);
    tests++;
    if (done1 !== 1'b0 || cycle1 !== 64'd49) begin
      fails++;
      $display("FAIL pass1_pre got done=%b cyc=%0d exp done=0 cyc=49", done1, cycle1);
    end
    ch_valid1 = 1'b1; ch_data1 = 64'd1;
    step(1);
    ch_valid1 = 1'b0; ch_data1 = '0;
    tests++;
    if ({done1, pass1, fail1, reason1, cycle1} !== {1'b1, 1'b1, 1'b0, 3'd1, 64'd50}) begin
      fails++;
      $display("FAIL pass1_verdict got d=%b p=%b f=%b r=%0d cyc=%0d exp d=1 p=1 f=0 r=1 cyc=50",
               done1, pass1, fail1, reason1, cycle1);
    end
    step(20);
    tests++;
    if ({done1, pass1, cycle1, dump_en1} !== {1'b1, 1'b1, 64'd50, 1'b0}) begin
      fails++;
      $display("FAIL pass1_frozen got d=%b p=%b cyc=%0d dump=%b exp d=1 p=1 cyc=50 dump=0",
               done1, pass1, cycle1, dump_en1);
    end
  endtask

  task automatic test_tohost_fail();
    do_reset();
    step(9);
    wr2(2'b01, 64'd1, 64'd0);
    step(4);
    wr2(2'b01, 64'd3, 64'd0);
    tests++;
    if (done2 !== 1'b0 || cycle2 !== 64'd15) begin
      fails++;
      $display("FAIL passed_ch_ignored got done=%b cyc=%0d exp done=0 cyc=15", done2, cycle2);
    end
    step(4);
    wr2(2'b10, 64'd0, 64'h7);
    tests++;
    if ({done2, pass2, fail2, reason2, fail_code2, fail_chan2, cycle2} !==
        {1'b1, 1'b0, 1'b1, 3'd2, 63'd3, 1'b1, 64'd20}) begin
      fails++;
      $display("FAIL tohost_fail got d=%b p=%b f=%b r=%0d code=%0d ch=%0d cyc=%0d exp d=1 p=0 f=1 r=2 code=3 ch=1 cyc=20",
               done2, pass2, fail2, reason2, fail_code2, fail_chan2, cycle2);
    end
  endtask

  task automatic test_pass_two();
    do_reset();
    step(2);
    wr2(2'b10, 64'd0, 64'd1);
    tests++;
    if (done2 !== 1'b0) begin
      fails++;
      $display("FAIL pass2_partial got done=%b exp 0", done2);
    end
    step(3);
    wr2(2'b01, 64'd1, 64'd0);
    tests++;
    if ({done2, pass2, fail2, reason2, cycle2} !== {1'b1, 1'b1, 1'b0, 3'd1, 64'd7}) begin
      fails++;
      $display("FAIL pass2_verdict got d=%b p=%b f=%b r=%0d cyc=%0d exp d=1 p=1 f=0 r=1 cyc=7",
               done2, pass2, fail2, reason2, cycle2);
    end
  endtask

  task automatic test_priority();
    do_reset();
    step(4);
    wr2(2'b01, 64'h100, 64'd0);
    tests++;
    if (done2 !== 1'b0) begin
      fails++;
      $display("FAIL even_write_ignored got done=%b exp 0", done2);
    end
    step(2);
    wr2(2'b11, 64'h5, 64'hB);
    tests++;
    if ({fail2, reason2, fail_code2, fail_chan2, cycle2} !== {1'b1, 3'd2, 63'd2, 1'b0, 64'd8}) begin
      fails++;
      $display("FAIL lowest_chan got f=%b r=%0d code=%0d ch=%0d cyc=%0d exp f=1 r=2 code=2 ch=0 cyc=8",
               fail2, reason2, fail_code2, fail_chan2, cycle2);
    end
    do_reset();
    step(3);
    wr2(2'b11, 64'd1, 64'd3);
    tests++;
    if ({pass2, fail2, reason2, fail_code2, fail_chan2} !== {1'b0, 1'b1, 3'd2, 63'd1, 1'b1}) begin
      fails++;
      $display("FAIL fail_over_pass got p=%b f=%b r=%0d code=%0d ch=%0d exp p=0 f=1 r=2 code=1 ch=1",
               pass2, fail2, reason2, fail_code2, fail_chan2);
    end
  endtask

  task automatic test_timeout();
    cfg_max_cycles = 64'd100;
    do_reset();
    step(100);
    tests++;
    if (done2 !== 1'b0 || cycle2 !== 64'd100) begin
      fails++;
      $display("FAIL timeout_pre got done=%b cyc=%0d exp done=0 cyc=100", done2, cycle2);
    end
    step(1);
    tests++;
    if ({done2, fail2, reason2, fail_code2, fail_chan2, cycle2} !==
        {1'b1, 1'b1, 3'd3, 63'd0, 1'b0, 64'd101}) begin
      fails++;
      $display("FAIL timeout got d=%b f=%b r=%0d code=%0d ch=%0d cyc=%0d exp d=1 f=1 r=3 code=0 ch=0 cyc=101",
               done2, fail2, reason2, fail_code2, fail_chan2, cycle2);
    end
    step(5);
    tests++;
    if (cycle2 !== 64'd101) begin
      fails++;
      $display("FAIL timeout_frozen got cyc=%0d exp 101", cycle2);
    end
    cfg_max_cycles = '0;
    do_reset();
    step(1000);
    tests++;
    if (done2 !== 1'b0 || cycle2 !== 64'd1000) begin
      fails++;
      $display("FAIL timeout_disabled got done=%b cyc=%0d exp done=0 cyc=1000", done2, cycle2);
    end
  endtask

  task automatic test_stall();
`ifdef SIM_EXIT_STALL_WATCHDOG_EN
    do_reset();
    step(5);
    commit2 = 2'b10;
    step(15);
    tests++;
    if (done2 !== 1'b0) begin
      fails++;
      $display("FAIL stall_pre got done=%b exp 0 at cycle 20", done2);
    end
    step(1);
    tests++;
    if ({fail2, reason2, fail_code2, fail_chan2, cycle2} !== {1'b1, 3'd4, 63'd0, 1'b0, 64'd21}) begin
      fails++;
      $display("FAIL stall got f=%b r=%0d code=%0d ch=%0d cyc=%0d exp f=1 r=4 code=0 ch=0 cyc=21",
               fail2, reason2, fail_code2, fail_chan2, cycle2);
    end
    do_reset();
    step(5);
    commit2 = 2'b10;
    step(9);
    commit2 = 2'b11;
    step(1);
    commit2 = 2'b10;
    step(15);
    tests++;
    if (done2 !== 1'b0) begin
      fails++;
      $display("FAIL stall_recommit_pre got done=%b exp 0 at cycle 30", done2);
    end
    step(1);
    tests++;
    if ({fail2, reason2, fail_chan2, cycle2} !== {1'b1, 3'd4, 1'b0, 64'd31}) begin
      fails++;
      $display("FAIL stall_recommit got f=%b r=%0d ch=%0d cyc=%0d exp f=1 r=4 ch=0 cyc=31",
               fail2, reason2, fail_chan2, cycle2);
    end
    do_reset();
    commit2 = 2'b00;
    wr2(2'b01, 64'd1, 64'd0);
    step(14);
    tests++;
    if (done2 !== 1'b0) begin
      fails++;
      $display("FAIL stall_ch1_pre got done=%b exp 0 at cycle 15", done2);
    end
    step(1);
    tests++;
    if ({fail2, reason2, fail_chan2, cycle2} !== {1'b1, 3'd4, 1'b1, 64'd16}) begin
      fails++;
      $display("FAIL stall_passed_frozen got f=%b r=%0d ch=%0d cyc=%0d exp f=1 r=4 ch=1 cyc=16",
               fail2, reason2, fail_chan2, cycle2);
    end
`else
    do_reset();
    commit2 = 2'b00;
    step(40);
    tests++;
    if (done2 !== 1'b0 || cycle2 !== 64'd40) begin
      fails++;
      $display("FAIL no_watchdog got done=%b cyc=%0d exp done=0 cyc=40", done2, cycle2);
    end
`endif
    commit2 = 2'b11;
  endtask

  task automatic test_dump();
    cfg_dump_start = '0; cfg_dump_stop = 64'd40;
    do_reset();
    step(39);
    tests++;
    if (dump_en2 !== 1'b1 || cycle2 !== 64'd39) begin
      fails++;
      $display("FAIL dump_in_window got dump=%b cyc=%0d exp dump=1 cyc=39", dump_en2, cycle2);
    end
    step(1);
    tests++;
    if (dump_en2 !== 1'b0) begin
      fails++;
      $display("FAIL dump_stop got dump=%b exp 0 at cycle 40", dump_en2);
    end
    cfg_dump_start = 64'd5; cfg_dump_stop = '0;
    reset = 1'b1;
    step(1);
    tests++;
    if (dump_en2 !== 1'b0) begin
      fails++;
      $display("FAIL dump_reset_start5 got dump=%b exp 0", dump_en2);
    end
    do_reset();
    step(4);
    tests++;
    if (dump_en2 !== 1'b0) begin
      fails++;
      $display("FAIL dump_before_start got dump=%b exp 0 at cycle 4", dump_en2);
    end
    step(1);
    tests++;
    if (dump_en2 !== 1'b1) begin
      fails++;
      $display("FAIL dump_start got dump=%b exp 1 at cycle 5", dump_en2);
    end
  endtask

  task automatic test_async_reset();
    cfg_dump_start = '0; cfg_dump_stop = 64'd40;
    do_reset();
    step(24);
    ch_valid1 = 1'b1; ch_data1 = 64'h9;
    step(1);
    ch_valid1 = 1'b0; ch_data1 = '0;
    step(5);
    tests++;
    if ({fail1, fail_code1, cycle1, cycle2, dump_en2} !== {1'b1, 63'd4, 64'd25, 64'd30, 1'b1}) begin
      fails++;
      $display("FAIL async_pre got f1=%b code1=%0d cyc1=%0d cyc2=%0d dump2=%b exp f1=1 code1=4 cyc1=25 cyc2=30 dump2=1",
               fail1, fail_code1, cycle1, cycle2, dump_en2);
    end
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if ({done1, pass1, fail1, reason1, fail_code1, fail_chan1, cycle1, dump_en1} !==
        {1'b0, 1'b0, 1'b0, 3'd0, 63'd0, 1'b0, 64'd0, 1'b1}) begin
      fails++;
      $display("FAIL async_reset_dut1 got d=%b p=%b f=%b r=%0d code=%0d ch=%0d cyc=%0d dump=%b exp all 0, dump=1",
               done1, pass1, fail1, reason1, fail_code1, fail_chan1, cycle1, dump_en1);
    end
    tests++;
    if ({done2, fail2, reason2, cycle2, dump_en2} !== {1'b0, 1'b0, 3'd0, 64'd0, 1'b1}) begin
      fails++;
      $display("FAIL async_reset_dut2 got d=%b f=%b r=%0d cyc=%0d dump=%b exp d=0 f=0 r=0 cyc=0 dump=1",
               done2, fail2, reason2, cycle2, dump_en2);
    end
  endtask

  initial begin
    test_reset();
    test_pass_single();
    test_tohost_fail();
    test_pass_two();
    test_priority();
    test_timeout();
    test_stall();
    test_dump();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
